fifo_rd_drain: RTL and testbench
================================

# fifo_rd_drain

Read-side drain controller for the asynchronous FIFO, clocked in the read domain. It issues `rd_en` against the FIFO's registered `data_out` port, absorbs the one-cycle read latency in a small elastic buffer, and presents words on a valid/ready stream toward downstream logic. It is the consumer end of the FIFO read interface: it owns `rd_en` and never reads while `fifo_empty` is high.

## Interface
- `FIFO_WIDTH`, 64, word width; must match the FIFO's `FIFO_WIDTH`.
- `BUF_DEPTH`, 4, elastic buffer entries; legal range 3..16 (3 is the minimum for one word per cycle).
- `rdclk`  in  1  read-domain clock; all logic is on its rising edge.
- `rrst`  in  1  synchronous, active-high reset.
- `en`  in  1  drain enable; while low, no new reads are issued.
- `fifo_empty`  in  1  FIFO empty flag, registered in `rdclk`.
- `data_out`  in  FIFO_WIDTH  FIFO read data, valid the cycle after an accepted `rd_en`.
- `rd_en`  out  1  FIFO read strobe (combinational).
- `m_valid`  out  1  stream word valid.
- `m_data`  out  FIFO_WIDTH  stream word (head of buffer).
- `m_ready`  in  1  downstream accept.
- `busy`  out  1  high in RUN or DRAIN.
- `word_cnt`  out  16  accepted-word counter; present only with `FIFO_RD_DRAIN_CNT_EN`.

## Operation
- `occ`: number of buffer entries holding words, 0..BUF_DEPTH.
- `inflight`: 1-bit register, set the cycle after `rd_en` is issued.
- `rd_en = (state==RUN) & en & !fifo_empty & (occ + inflight < BUF_DEPTH)`.
  - Pop lookahead is not used.
  - Because `rd_en` requires `!fifo_empty`, the FIFO accepts every strobe issued.
- Capture: if `inflight`==1, `data_out` is written at the tail this cycle.
- Pop: `m_valid & m_ready` removes the head.
- Push and pop in the same cycle leave `occ` unchanged.
- Buffer:
  - Circular, with log2-width head and tail pointers that wrap at BUF_DEPTH.
  - Arbitrary BUF_DEPTH requires explicit wrap compare, not power-of-2 overflow.
- `m_valid = (occ != 0)`; `m_data` = buffer[head]. Both are stable until accepted.
- State machine:
  - IDLE: `en`=1 → RUN.
  - RUN: `en`=0 → DRAIN.
  - DRAIN: no new reads. `inflight`=0 → IDLE.
  - Buffered words keep flowing out in every state; they are not flushed.
- `busy = (state != IDLE)`.
- Boundary conditions:
  - `fifo_empty` rising while `inflight`=1: the in-flight word is still captured.
  - `occ==BUF_DEPTH`: `rd_en` held low. The buffer never overflows, because `occ + inflight` is bounded.
  - `en` dropping in the same cycle as a `rd_en`: that read completes normally in DRAIN.
  - `m_ready` high with `occ`=0: no effect.

## Timing
- Reset values:
  - `state`=IDLE, `occ`=0, `inflight`=0, head and tail at 0.
  - Outputs: `rd_en`=0, `m_valid`=0, `busy`=0, `word_cnt`=0, `m_data` undefined.
- Reset mid-operation: all state is cleared on the next edge.
  - An in-flight FIFO read word is discarded.
  - The integrator must reset the FIFO read side together with this block.
- Latency, with the buffer empty and `m_ready`=1:
  - `rd_en` at cycle N → `m_valid` at cycle N+2.
  - The word is captured at edge N+1 and exposed from the buffer.
- Throughput: one word per cycle sustained when BUF_DEPTH≥3, `m_ready`=1 and `fifo_empty`=0.
- Handshake: `m_valid` never deasserts without acceptance; `m_data` does not change while `m_valid & !m_ready`.

## Configuration
- `FIFO_RD_DRAIN_CNT_EN` defined:
  - Adds a 16-bit `word_cnt` port that increments on each `m_valid & m_ready`.
  - Wraps 0xFFFF→0x0000; cleared by `rrst`.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Test plan
- Basic: `en`=1, FIFO holds 8 words 0x00..0x07, `m_ready`=1 → the stream emits 0x00..0x07 in order on 8 consecutive cycles starting 2 cycles after the first `rd_en`. `rd_en` is never high while `fifo_empty`=1.
- Backpressure: `m_ready`=0 with 10 words available → exactly BUF_DEPTH (4) reads issue, then `rd_en` stays 0. Raising `m_ready` releases 0x00.. in order, with no loss or duplication.
- Empty edge: 1 word in the FIFO → one `rd_en`, `fifo_empty` rises, the word is still delivered, and no further reads issue.
- Drain: drop `en` in the cycle a `rd_en` fires → state DRAIN, the in-flight word is delivered, `busy` falls one cycle after `inflight` clears, and the remaining FIFO words are untouched.
- Reset mid-stream: assert `rrst` with `occ`=3 and `inflight`=1 → the next cycle shows `m_valid`=0, `busy`=0, `rd_en`=0, and `word_cnt`=0 when `FIFO_RD_DRAIN_CNT_EN` is defined.
- Counter (`FIFO_RD_DRAIN_CNT_EN`): preload via 65537 accepted words → `word_cnt`=1. Built without the macro, the elaborated port list has no `word_cnt`.

Source files
------------

// File: rtl/fifo_rd_drain.sv
// Read-side drain controller: issues rd_en to the FIFO, absorbs its one-cycle read latency
// in a circular elastic buffer, and streams words out on valid/ready. Optional macro FIFO_RD_DRAIN_CNT_EN adds word_cnt.
module fifo_rd_drain #(
  parameter int FIFO_WIDTH = 64,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  rdclk,
  input  logic                  rrst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] data_out,
  output logic                  rd_en,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy
`ifdef FIFO_RD_DRAIN_CNT_EN
  ,
  output logic [15:0]           word_cnt
`endif
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(BUF_DEPTH - 1);
  localparam logic [OW:0]   DEPTH_W  = (OW+1)'(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state_q;
  logic [OW-1:0]         occ_q;
  logic [OW-1:0]         occ_d;
  logic [PW-1:0]         head_q;
  logic [PW-1:0]         tail_q;
  logic                  inflight_q;
  logic [FIFO_WIDTH-1:0] buf_q [BUF_DEPTH];
  logic                  push;
  logic                  pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Reserving a slot for the in-flight word keeps occ within BUF_DEPTH.
  assign rd_en   = (state_q == RUN) & en & ~fifo_empty &
                   (({1'b0, occ_q} + (OW+1)'(inflight_q)) < DEPTH_W);
  assign push    = inflight_q;
  assign pop     = m_valid & m_ready;
  assign m_valid = (occ_q != '0);
  assign m_data  = buf_q[head_q];
  assign busy    = (state_q != IDLE);

  always_comb begin
    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + OW'(1);
    end else if (!push && pop) begin
      occ_d = occ_q - OW'(1);
    end
  end

  always_ff @(posedge rdclk) begin
    if (push) begin
      buf_q[tail_q] <= data_out;
    end
  end

  always_ff @(posedge rdclk) begin
    if (rrst) begin
      state_q    <= IDLE;
      occ_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_en;
      occ_q      <= occ_d;
      if (push) begin
        tail_q <= wrap_inc(tail_q);
      end
      if (pop) begin
        head_q <= wrap_inc(head_q);
      end
      case (state_q)
        IDLE:    if (en)          state_q <= RUN;
        RUN:     if (!en)         state_q <= DRAIN;
        DRAIN:   if (!inflight_q) state_q <= IDLE;
        default:                  state_q <= IDLE;
      endcase
    end
  end

`ifdef FIFO_RD_DRAIN_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge rdclk) begin
    if (rrst) begin
      cnt_q <= '0;
    end else if (pop) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign word_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: queue-based FIFO model on the read side and a scoreboard on the stream side.
module tb_fifo_rd_drain;
  localparam int W = 64;
  localparam int D = 4;

  logic         rdclk = 1'b0;
  logic         rrst = 1'b1;
  logic         en = 1'b0;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] data_out = '0;
  logic         rd_en;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_ready = 1'b0;
  logic         busy;
`ifdef FIFO_RD_DRAIN_CNT_EN
  logic [15:0]  word_cnt;
`endif

  always #5 rdclk = ~rdclk;

  fifo_rd_drain #(.FIFO_WIDTH(W), .BUF_DEPTH(D)) dut (
    .rdclk      (rdclk),
    .rrst       (rrst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .data_out   (data_out),
    .rd_en      (rd_en),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .busy       (busy)
`ifdef FIFO_RD_DRAIN_CNT_EN
    ,
    .word_cnt   (word_cnt)
`endif
  );

  logic [W-1:0] fifo_m[$];
  logic [W-1:0] exp_q[$];
  int           acc_cyc[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  int           acc_cnt = 0;
  int           rd_cnt = 0;
  int           first_rd = -1;
  bit           quiet = 1'b0;
  logic         rd_s = 1'b0;
  logic         pv = 1'b0;
  logic         pr = 1'b0;
  logic         prst = 1'b1;
  logic [W-1:0] pd = '0;

  // FIFO read port model: registered data_out and empty flag.
  always @(posedge rdclk) begin
    cyc <= cyc + 1;
    if (rd_s && fifo_m.size() > 0) data_out <= fifo_m.pop_front();
    fifo_empty <= (fifo_m.size() == 0);
  end

  // Stream monitor and scoreboard, sampled mid-cycle.
  always @(negedge rdclk) begin
    logic [W-1:0] e;
    if (!rrst) begin
      n_cmp++;
      if (rd_en && fifo_empty) begin
        n_bad++;
        $display("FAIL rd_en_while_empty: rd_en=%0b fifo_empty=%0b required rd_en=0 (cycle %0d)", rd_en, fifo_empty, cyc);
      end
      if (rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (pv && !pr && !prst) begin
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== pd) begin
          n_bad++;
          $display("FAIL hold: m_valid=%0b m_data=%0h required 1 / %0h (cycle %0d)", m_valid, m_data, pd, cyc);
        end
      end
      if (m_valid && m_ready) begin
        acc_cnt++;
        acc_cyc.push_back(cyc);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_word: got %0h, scoreboard empty (cycle %0d)", m_data, cyc);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin
            n_bad++;
            $display("FAIL stream_data: got %0h required %0h (cycle %0d)", m_data, e, cyc);
          end else if (!quiet) begin
            $display("accept data=%0h cycle=%0d", m_data, cyc);
          end
        end
      end
    end
    rd_s <= rd_en;
    pv   <= m_valid;
    pr   <= m_ready;
    pd   <= m_data;
    prst <= rrst;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge rdclk);
    #1;
  endtask

  task automatic load(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) begin
      fifo_m.push_back(base + W'(i));
      exp_q.push_back(base + W'(i));
    end
  endtask

  task automatic test_reset();
    rrst = 1'b1;
    tick(2);
    n_cmp++;
    if (rd_en !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: rd_en=%0b m_valid=%0b busy=%0b required 0/0/0", rd_en, m_valid, busy);
    end
`ifdef FIFO_RD_DRAIN_CNT_EN
    n_cmp++;
    if (word_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_word_cnt: got %0d required 0", word_cnt);
    end
`endif
    rrst = 1'b0;
    tick(1);
  endtask

  task automatic test_basic();
    int a0;
    m_ready = 1'b1;
    tick(2);
    n_cmp++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_ready_no_effect: m_valid=%0b busy=%0b required 0/0", m_valid, busy);
    end
    acc_cyc.delete();
    first_rd = -1;
    a0 = acc_cnt;
    load(8, 64'h0);
    en = 1'b1;
    for (int i = 0; i < 60 && acc_cnt < a0 + 8; i++) tick(1);
    n_cmp++;
    if (acc_cnt - a0 != 8) begin
      n_bad++;
      $display("FAIL basic_count: got %0d words required 8", acc_cnt - a0);
    end
    if (acc_cyc.size() > 0) begin
      n_cmp++;
      if (acc_cyc[0] - first_rd != 2) begin
        n_bad++;
        $display("FAIL basic_latency: got %0d cycles required 2", acc_cyc[0] - first_rd);
      end
      for (int i = 1; i < acc_cyc.size(); i++) begin
        n_cmp++;
        if (acc_cyc[i] != acc_cyc[0] + i) begin
          n_bad++;
          $display("FAIL basic_throughput: word %0d at cycle %0d required %0d", i, acc_cyc[i], acc_cyc[0] + i);
        end
      end
    end
    en = 1'b0;
    tick(4);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_busy_end: got %0b required 0", busy);
    end
  endtask

  task automatic test_backpressure();
    int r0;
    int a0;
    m_ready = 1'b0;
    r0 = rd_cnt;
    a0 = acc_cnt;
    load(10, 64'h100);
    en = 1'b1;
    tick(20);
    n_cmp++;
    if (rd_cnt - r0 != D) begin
      n_bad++;
      $display("FAIL bp_reads: got %0d reads required %0d", rd_cnt - r0, D);
    end
    n_cmp++;
    if (rd_en !== 1'b0 || m_valid !== 1'b1 || m_data !== 64'h100) begin
      n_bad++;
      $display("FAIL bp_full: rd_en=%0b m_valid=%0b m_data=%0h required 0/1/100", rd_en, m_valid, m_data);
    end
    n_cmp++;
    if (fifo_m.size() != 10 - D) begin
      n_bad++;
      $display("FAIL bp_fifo_left: got %0d required %0d", fifo_m.size(), 10 - D);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 60 && acc_cnt < a0 + 10; i++) tick(1);
    n_cmp++;
    if (acc_cnt - a0 != 10 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL bp_release: got %0d words, %0d pending required 10/0", acc_cnt - a0, exp_q.size());
    end
    en = 1'b0;
    tick(4);
  endtask

  task automatic test_empty_edge();
    int r0;
    m_ready = 1'b1;
    r0 = rd_cnt;
    load(1, 64'h200);
    en = 1'b1;
    tick(10);
    n_cmp++;
    if (rd_cnt - r0 != 1 || exp_q.size() != 0 || fifo_empty !== 1'b1) begin
      n_bad++;
      $display("FAIL empty_edge: reads=%0d pending=%0d fifo_empty=%0b required 1/0/1", rd_cnt - r0, exp_q.size(), fifo_empty);
    end
    en = 1'b0;
    tick(4);
  endtask

  task automatic test_drain();
    int r0;
    m_ready = 1'b1;
    r0 = rd_cnt;
    load(6, 64'h300);
    en = 1'b1;
    for (int i = 0; i < 20 && rd_en !== 1'b1; i++) tick(1);
    n_cmp++;
    if (rd_en !== 1'b1) begin
      n_bad++;
      $display("FAIL drain_first_read: rd_en=%0b required 1 within bound", rd_en);
    end
    tick(1);
    en = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b1 || rd_en !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_run: busy=%0b rd_en=%0b required 1/0", busy, rd_en);
    end
    tick(1);
    n_cmp++;
    if (busy !== 1'b1 || rd_en !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_state: busy=%0b rd_en=%0b required 1/0", busy, rd_en);
    end
    tick(1);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_busy_fall: got %0b required 0", busy);
    end
    tick(3);
    n_cmp++;
    if (rd_cnt - r0 != 1 || fifo_m.size() != 5 || exp_q.size() != 5) begin
      n_bad++;
      $display("FAIL drain_untouched: reads=%0d fifo=%0d pending=%0d required 1/5/5", rd_cnt - r0, fifo_m.size(), exp_q.size());
    end
    fifo_m.delete();
    exp_q.delete();
    tick(2);
  endtask

  task automatic test_reset_mid();
    int r0;
    m_ready = 1'b0;
    r0 = rd_cnt;
    load(10, 64'h400);
    en = 1'b1;
    for (int i = 0; i < 20 && rd_cnt - r0 < D; i++) tick(1);
    n_cmp++;
    if (m_valid !== 1'b1 || rd_en !== 1'b0 || rd_cnt - r0 != D) begin
      n_bad++;
      $display("FAIL mid_prep: m_valid=%0b rd_en=%0b reads=%0d required 1/0/%0d", m_valid, rd_en, rd_cnt - r0, D);
    end
    rrst = 1'b1;
    tick(1);
    n_cmp++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: m_valid=%0b busy=%0b rd_en=%0b required 0/0/0", m_valid, busy, rd_en);
    end
`ifdef FIFO_RD_DRAIN_CNT_EN
    n_cmp++;
    if (word_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL mid_reset_cnt: got %0d required 0", word_cnt);
    end
`endif
    en = 1'b0;
    fifo_m.delete();
    exp_q.delete();
    tick(2);
    rrst = 1'b0;
    tick(2);
  endtask

`ifdef FIFO_RD_DRAIN_CNT_EN
  task automatic test_counter();
    int a0;
    a0 = acc_cnt;
    quiet = 1'b1;
    m_ready = 1'b1;
    load(65537, 64'h10000);
    en = 1'b1;
    for (int i = 0; i < 66000 && acc_cnt < a0 + 65537; i++) tick(1);
    quiet = 1'b0;
    n_cmp++;
    if (acc_cnt - a0 != 65537 || word_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL counter_wrap: words=%0d word_cnt=%0d required 65537/1", acc_cnt - a0, word_cnt);
    end
    en = 1'b0;
    tick(4);
  endtask
`endif

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_edge();
    test_drain();
    test_reset_mid();
`ifdef FIFO_RD_DRAIN_CNT_EN
    test_counter();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
